tdm2p: RTL and testbench
========================

TDM2P -- requirements
Module: tdm2p

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 256, serial bits per TDM frame (multiple of 8, at least 16).
REQ-002 SHALL have parameter LOCK_FRAMES, default 2, consecutive good frames needed to assert locked (1..3).
REQ-003 SHALL have port sclk, input, 1, serial bit clock; all logic on its rising edge; the only clock.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port enable, input, 1, receiver enable.
REQ-006 SHALL have port pattern, input, 8, expected frame header.
REQ-007 SHALL have port mask, input, 8, per-bit header compare enable (1 = compare).
REQ-008 SHALL have port tdmin, input, 1, serial data, MSB of frame first.
REQ-009 SHALL have port fsin, input, 1, frame sync, high during the cycle carrying frame bit 0.
REQ-010 SHALL have port pvalid, output, 1, one-cycle pulse, pdata holds a good frame.
REQ-011 SHALL have port pdata, output, FRAME_BITS, last good frame; first bit received is at pdata[FRAME_BITS-1].
REQ-012 SHALL have port locked, output, 1, frame alignment status.
REQ-013 SHALL have port sync_err, output, 1, one-cycle pulse on any framing or header error.
REQ-014 SHALL have port frame_cnt, output, 16, count of good frames; wraps 0xFFFF->0x0000.

Function
REQ-015 SHALL implement states IDLE, HUNT, SHIFT; enable=0 forces IDLE from any state on the next edge.
REQ-016 IDLE: enable=1 -> HUNT; no data captured.
REQ-017 HUNT: fsin=1 -> capture tdmin as bit 0, bit_cnt=1, go SHIFT; fsin=0 -> stay, bit discarded.
REQ-018 SHIFT: each cycle shifts tdmin into the shift register MSB-first and increments bit_cnt.
REQ-019 SHIFT: fsin=1 while bit_cnt is 1..FRAME_BITS-1 (short frame) -> sync_err pulse next cycle, partial frame discarded, current bit taken as bit 0 of a new frame.
REQ-020 On the cycle sampling bit FRAME_BITS-1, the frame is complete; header = first 8 bits received.
REQ-021 Header good when ((header XOR pattern) AND mask) == 0; mask=0x00 accepts every header.
REQ-022 Good frame: next cycle pdata = frame, pvalid=1 for exactly one cycle, frame_cnt+1; latency 1 cycle after last bit.
REQ-023 Bad header: next cycle sync_err=1 for one cycle, pdata unchanged, no pvalid.
REQ-024 After a complete frame, fsin=1 with the next bit -> bit 0 of next frame, stay SHIFT (back-to-back frames, no gap cycle).
REQ-025 After a complete frame, fsin=0 with the next bit (missing sync) -> sync_err pulse, bit discarded, go HUNT.
REQ-026 If a frame completes in the same cycle fsin=1 for bit 0 of the next frame, REQ-022/023 and REQ-024 both apply.
REQ-027 Lock counter saturates at LOCK_FRAMES; +1 per good frame; cleared by any sync_err event.
REQ-028 locked SHALL go to 1 in the same cycle as the pvalid of the LOCK_FRAMES-th consecutive good frame, and to 0 in the same cycle as any sync_err.
REQ-029 enable 1->0 mid-frame: partial frame discarded, no pvalid, no sync_err, locked=0; pdata and frame_cnt retained.
REQ-030 pattern/mask SHALL be sampled at frame completion only; changes mid-frame take effect at that check.

Reset
REQ-031 rst=1 at a clock edge SHALL force state IDLE, bit_cnt=0, shift register=0, lock counter=0.
REQ-032 During and after reset: pvalid=0, pdata=0, locked=0, sync_err=0, frame_cnt=0.
REQ-033 Reset mid-frame SHALL discard the partial frame with no pvalid or sync_err pulse; rst overrides enable.

Verification
REQ-034 pattern=0x3C, mask=0xFF, three back-to-back 256-bit frames with header 0x3C, payload 0xA5 repeated -> three pvalid pulses 256 cycles apart, pdata[255:248]=0x3C, locked=1 at second pvalid, frame_cnt=3.
REQ-035 Locked, then one frame with header 0x3D -> sync_err pulse at its completion, no pvalid, locked=0; next two good frames re-assert locked.
REQ-036 fsin pulse at bit 100 of a frame -> sync_err one cycle later, new frame starts at that bit, completes 256 cycles later with pvalid.
REQ-037 fsin absent after a good frame for 40 cycles, then present -> sync_err once, HUNT, next frame accepted normally.
REQ-038 mask=0x0F, pattern=0x3C, header 0xFC -> pvalid; header 0x3D -> sync_err.
REQ-039 rst or enable=0 at bit 128 -> no pvalid, no sync_err; after rst outputs are all 0; after enable=0, pdata and frame_cnt keep prior values.

Source files
------------

// File: rtl/tdm2p.sv
// TDM frame-to-parallel receiver.
// Hunts for frame sync, deserialises FRAME_BITS-bit frames (MSB first),
// validates an 8-bit masked header, and tracks frame alignment lock.
module tdm2p #(
    parameter int unsigned FRAME_BITS  = 256,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic                  sclk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [7:0]            pattern,
    input  logic [7:0]            mask,
    input  logic                  tdmin,
    input  logic                  fsin,
    output logic                  pvalid,
    output logic [FRAME_BITS-1:0] pdata,
    output logic                  locked,
    output logic                  sync_err,
    output logic [15:0]           frame_cnt
);

    localparam int unsigned CW = $clog2(FRAME_BITS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_BITS - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
    localparam logic [1:0]    LOCK_MAX = 2'(LOCK_FRAMES);

    typedef enum logic [1:0] {S_IDLE, S_HUNT, S_SHIFT} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_bit_cnt;
    // Only FRAME_BITS-1 bits need storing; the final bit is taken live from tdmin.
    logic [FRAME_BITS-2:0] r_shift;
    logic [1:0]            r_lock_cnt;
    logic [1:0]            w_lock_nxt;
    logic                  r_pvalid;
    logic [FRAME_BITS-1:0] r_pdata;
    logic                  r_locked;
    logic                  r_sync_err;
    logic [15:0]           r_frame_cnt;

    logic                  w_load;
    logic                  w_shift;
    logic                  w_complete;
    logic                  w_frame_err;
    logic                  w_hdr_ok;
    logic                  w_good;
    logic                  w_any_err;
    logic [FRAME_BITS-1:0] w_frame;

    assign w_frame   = {r_shift, tdmin};
    assign w_hdr_ok  = (((w_frame[FRAME_BITS-1 -: 8] ^ pattern) & mask) == 8'h00);
    assign w_good    = w_complete && w_hdr_ok;
    assign w_any_err = w_frame_err || (w_complete && !w_hdr_ok);
    assign w_lock_nxt = (r_lock_cnt == LOCK_MAX) ? LOCK_MAX : r_lock_cnt + 2'd1;

    // State register
    always_ff @(posedge sclk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; enable low wins from any state
    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_HUNT;
                S_HUNT:  if (fsin) w_state_nxt = S_SHIFT;
                S_SHIFT: if (!fsin && r_bit_cnt == CNT_FULL) w_state_nxt = S_HUNT;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Per-cycle datapath controls decoded from state, sync and bit position
    always_comb begin
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_complete  = 1'b0;
        w_frame_err = 1'b0;
        if (enable) begin
            case (r_state)
                S_HUNT: w_load = fsin;
                S_SHIFT: begin
                    if (fsin) begin
                        // Sync right after a full frame is a back-to-back start; earlier is a short frame.
                        w_load      = 1'b1;
                        w_frame_err = (r_bit_cnt != CNT_FULL);
                    end else if (r_bit_cnt == CNT_FULL) begin
                        w_frame_err = 1'b1;
                    end else begin
                        w_shift    = 1'b1;
                        w_complete = (r_bit_cnt == CNT_LAST);
                    end
                end
                default: ;
            endcase
        end
    end

    // Shift register and bit counter
    always_ff @(posedge sclk) begin
        if (rst) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_load) begin
            r_shift   <= {{(FRAME_BITS-2){1'b0}}, tdmin};
            r_bit_cnt <= CW'(1);
        end else if (w_shift) begin
            r_shift   <= {r_shift[FRAME_BITS-3:0], tdmin};
            r_bit_cnt <= r_bit_cnt + CW'(1);
        end else if (w_state_nxt != S_SHIFT) begin
            r_bit_cnt <= '0;
        end
    end

    // Frame outputs, error pulse and lock tracking
    always_ff @(posedge sclk) begin
        if (rst) begin
            r_pvalid    <= 1'b0;
            r_pdata     <= '0;
            r_locked    <= 1'b0;
            r_sync_err  <= 1'b0;
            r_frame_cnt <= '0;
            r_lock_cnt  <= '0;
        end else begin
            r_pvalid   <= 1'b0;
            r_sync_err <= 1'b0;
            if (!enable) begin
                r_lock_cnt <= '0;
                r_locked   <= 1'b0;
            end else if (w_good) begin
                r_pvalid    <= 1'b1;
                r_pdata     <= w_frame;
                r_frame_cnt <= r_frame_cnt + 16'd1;
                r_lock_cnt  <= w_lock_nxt;
                r_locked    <= (w_lock_nxt == LOCK_MAX);
            end else if (w_any_err) begin
                r_sync_err <= 1'b1;
                r_lock_cnt <= '0;
                r_locked   <= 1'b0;
            end
        end
    end

    assign pvalid    = r_pvalid;
    assign pdata     = r_pdata;
    assign locked    = r_locked;
    assign sync_err  = r_sync_err;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_tdm2p.sv
// Scoreboard bench for tdm2p: stimulus pushes expected pvalid/sync_err
// events, a negedge monitor pops and compares whenever the DUT pulses.
module tb_tdm2p;

    localparam int FB = 256;
    localparam int LK = 2;

    logic          sclk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b1;
    logic [7:0]    pattern = 8'h3C;
    logic [7:0]    mask = 8'hFF;
    logic          tdmin = 1'b0;
    logic          fsin = 1'b0;
    logic          pvalid;
    logic [FB-1:0] pdata;
    logic          locked;
    logic          sync_err;
    logic [15:0]   frame_cnt;

    tdm2p #(.FRAME_BITS(FB), .LOCK_FRAMES(LK)) dut (
        .sclk(sclk), .rst(rst), .enable(enable), .pattern(pattern), .mask(mask),
        .tdmin(tdmin), .fsin(fsin), .pvalid(pvalid), .pdata(pdata),
        .locked(locked), .sync_err(sync_err), .frame_cnt(frame_cnt)
    );

    always #5 sclk = ~sclk;

    int edge_n = 0;
    always @(posedge sclk) edge_n <= edge_n + 1;

    typedef struct {
        bit            is_err;
        logic [FB-1:0] data;
        logic [15:0]   cnt;
        logic          lck;
        int            edge_at;
    } exp_t;

    exp_t          sbq[$];
    exp_t          e;
    int            n_tests = 0;
    int            n_fail = 0;
    logic [15:0]   m_cnt = '0;
    int            m_lk = 0;
    logic [FB-1:0] m_pdata = '0;

    function automatic void chk(string nm, logic [FB-1:0] act, logic [FB-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    task automatic push_good(input logic [FB-1:0] f);
        m_cnt   = m_cnt + 16'd1;
        m_lk    = (m_lk < LK) ? m_lk + 1 : LK;
        m_pdata = f;
        sbq.push_back('{1'b0, f, m_cnt, (m_lk >= LK), edge_n + 1});
    endtask

    task automatic push_err();
        m_lk = 0;
        sbq.push_back('{1'b1, m_pdata, m_cnt, 1'b0, edge_n + 1});
    endtask

    task automatic send_bit(input logic b, input logic fs);
        tdmin = b;
        fsin  = fs;
        @(posedge sclk);
        #1;
    endtask

    // Sends the first nbits of a frame {hdr, fill...}; fsin accompanies bit 0.
    task automatic send_frame(input logic [7:0] hdr, input logic [7:0] fill, input int nbits,
                              input bit good, input bit err_first);
        logic [FB-1:0] f;
        f = {hdr, {(FB/8-1){fill}}};
        for (int i = 0; i < nbits; i++) begin
            if (i == 0 && err_first) push_err();
            if (i == FB - 1) begin
                if (good) push_good(f);
                else push_err();
            end
            send_bit(f[FB-1-i], i == 0);
        end
    endtask

    task automatic idle_bits(input int n, input bit err_first);
        for (int i = 0; i < n; i++) begin
            if (i == 0 && err_first) push_err();
            send_bit(1'b0, 1'b0);
        end
    endtask

    task automatic chk_static(string tag);
        chk({tag, "_pvalid"}, FB'(pvalid), FB'(1'b0));
        chk({tag, "_sync_err"}, FB'(sync_err), FB'(1'b0));
        chk({tag, "_locked"}, FB'(locked), FB'(1'b0));
        chk({tag, "_frame_cnt"}, FB'(frame_cnt), FB'(m_cnt));
        chk({tag, "_pdata"}, pdata, m_pdata);
    endtask

    // Monitor: every output pulse must match the oldest expected event
    always @(negedge sclk) begin
        if (pvalid === 1'b1 || sync_err === 1'b1) begin
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_event: pvalid=%0b sync_err=%0b at edge %0d, required none",
                         pvalid, sync_err, edge_n);
            end else begin
                e = sbq.pop_front();
                chk("event_edge", FB'(edge_n), FB'(e.edge_at));
                chk("event_pvalid", FB'(pvalid), FB'(!e.is_err));
                chk("event_sync_err", FB'(sync_err), FB'(e.is_err));
                chk("event_locked", FB'(locked), FB'(e.lck));
                chk("event_frame_cnt", FB'(frame_cnt), FB'(e.cnt));
                if (!e.is_err) chk("event_pdata", pdata, e.data);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        // Reset with enable high: reset must dominate
        repeat (3) send_bit(1'b1, 1'b1);
        chk_static("reset");

        rst = 1'b0;
        send_bit(1'b0, 1'b0);          // IDLE -> HUNT
        idle_bits(5, 1'b0);            // discarded while hunting

        // Three back-to-back good frames, lock at the second
        repeat (3) send_frame(8'h3C, 8'hA5, FB, 1'b1, 1'b0);

        // Bad header drops lock; two good frames restore it
        send_frame(8'h3D, 8'hA5, FB, 1'b0, 1'b0);
        repeat (2) send_frame(8'h3C, 8'hA5, FB, 1'b1, 1'b0);

        // Short frame: sync arrives at bit 100, new frame starts there
        send_frame(8'h3C, 8'h11, 100, 1'b1, 1'b0);
        send_frame(8'h3C, 8'h22, FB, 1'b1, 1'b1);

        // Missing sync for 40 cycles, then a normal frame from HUNT
        idle_bits(40, 1'b1);
        send_frame(8'h3C, 8'h33, FB, 1'b1, 1'b0);

        // Partial mask: only low nibble compared
        mask = 8'h0F;
        send_frame(8'hFC, 8'h44, FB, 1'b1, 1'b0);
        send_frame(8'h3D, 8'h55, FB, 1'b0, 1'b0);
        repeat (2) send_frame(8'h3C, 8'h66, FB, 1'b1, 1'b0);

        // enable drop at bit 128: nothing emitted, data and count retained
        send_frame(8'h3C, 8'h88, 128, 1'b1, 1'b0);
        enable = 1'b0;
        send_bit(1'b1, 1'b0);
        m_lk = 0;
        repeat (3) send_bit(1'b0, 1'b0);
        chk("disable_frame_cnt_nonzero", FB'(frame_cnt == 16'd0), FB'(1'b0));
        chk_static("disable");

        enable = 1'b1;
        send_bit(1'b0, 1'b0);
        send_frame(8'h3C, 8'h99, FB, 1'b1, 1'b0);

        // Reset at bit 128 clears everything
        send_frame(8'h3C, 8'hAA, 128, 1'b1, 1'b0);
        rst = 1'b1;
        repeat (2) send_bit(1'b1, 1'b1);
        m_cnt = '0;
        m_lk = 0;
        m_pdata = '0;
        chk_static("midreset");

        rst = 1'b0;
        send_bit(1'b0, 1'b0);
        send_frame(8'h3C, 8'hBB, FB, 1'b1, 1'b0);
        enable = 1'b0;
        repeat (4) send_bit(1'b0, 1'b0);

        chk("scoreboard_drained", FB'(sbq.size()), FB'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
